// File: rtl/reservation_station_if.sv
// ----------------------------------------------------------------------------
// reservation_station_if
//
// Purpose: bundles every non-clock/reset signal between the dispatcher, the
// ALU/LSB broadcast buses and the reservation station into one interface.
//
// Signal summary:
//   rdy                        global enable; when low the station holds state
//   dispatch_rs_en ... pc      new instruction from the dispatcher
//   is_clear                   ROB misprediction flush
//   is_ok / val / rob_id       ALU result broadcast
//   lsb_ok / val / rob_id      LSB result broadcast
//   rs_full                    back-pressure to fetch (fewer than 2 free slots)
//   alu_*                      registered issue port towards the ALU
//
// Modports:
//   master : dispatcher / broadcast side (drives the station's inputs)
//   slave  : reservation station
// ----------------------------------------------------------------------------
interface reservation_station_if;
    logic        rdy;
    logic        dispatch_rs_en;
    logic [5:0]  dis_opcode;
    logic [3:0]  dis_rob_id;
    logic [31:0] Vi;
    logic [31:0] Vj;
    logic [3:0]  Qi;
    logic [3:0]  Qj;
    logic        Oi;
    logic        Oj;
    logic [31:0] imm_from_dpc;
    logic [31:0] once_pc_from_dpc;
    logic        is_clear;
    logic        is_ok;
    logic [31:0] val_from_alu;
    logic [3:0]  rob_id_from_alu;
    logic        lsb_ok;
    logic [31:0] val_from_lsb;
    logic [3:0]  rob_id_from_lsb;
    logic        rs_full;
    logic        alu_en;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_v1;
    logic [31:0] alu_v2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_id;

    modport master (
        output rdy, dispatch_rs_en, dis_opcode, dis_rob_id,
        output Vi, Vj, Qi, Qj, Oi, Oj, imm_from_dpc, once_pc_from_dpc,
        output is_clear, is_ok, val_from_alu, rob_id_from_alu,
        output lsb_ok, val_from_lsb, rob_id_from_lsb,
        input  rs_full, alu_en, alu_opcode, alu_v1, alu_v2,
        input  alu_imm, alu_pc, alu_rob_id
    );

    modport slave (
        input  rdy, dispatch_rs_en, dis_opcode, dis_rob_id,
        input  Vi, Vj, Qi, Qj, Oi, Oj, imm_from_dpc, once_pc_from_dpc,
        input  is_clear, is_ok, val_from_alu, rob_id_from_alu,
        input  lsb_ok, val_from_lsb, rob_id_from_lsb,
        output rs_full, alu_en, alu_opcode, alu_v1, alu_v2,
        output alu_imm, alu_pc, alu_rob_id
    );
endinterface

// File: rtl/reservation_station.sv
// ----------------------------------------------------------------------------
// reservation_station
//
// Purpose: Tomasulo reservation station for non-load/store instructions.
// Buffers dispatched instructions with operand values or producer ROB tags,
// snoops the ALU and LSB broadcast buses to wake waiting operands, and issues
// at most one ready entry per cycle to the ALU through registered outputs.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : reservation_station_if.slave (dispatch, broadcasts, flush,
//          back-pressure and ALU issue port)
//
// Parameters:
//   RS_SIZE : number of entries (power of two, >= 4)
//   IDX_W   : log2(RS_SIZE)
// ----------------------------------------------------------------------------
module reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    reservation_station_if.slave  bus
);

    localparam int TAG_W = 4;
    localparam int CNT_W = IDX_W + 1;

    // Entry storage
    logic [RS_SIZE-1:0] r_busy;
    logic [5:0]         r_opcode [RS_SIZE];
    logic [31:0]        r_v1     [RS_SIZE];
    logic [31:0]        r_v2     [RS_SIZE];
    logic [TAG_W-1:0]   r_q1     [RS_SIZE];
    logic [TAG_W-1:0]   r_q2     [RS_SIZE];
    logic [RS_SIZE-1:0] r_o1;
    logic [RS_SIZE-1:0] r_o2;
    logic [31:0]        r_imm    [RS_SIZE];
    logic [31:0]        r_pc     [RS_SIZE];
    logic [TAG_W-1:0]   r_rob    [RS_SIZE];

    // Registered issue port
    logic               r_alu_en;
    logic [5:0]         r_alu_opcode;
    logic [31:0]        r_alu_v1;
    logic [31:0]        r_alu_v2;
    logic [31:0]        r_alu_imm;
    logic [31:0]        r_alu_pc;
    logic [TAG_W-1:0]   r_alu_rob_id;

    // Combinational helpers
    logic [CNT_W-1:0]   w_free_cnt;
    logic               w_alloc_found;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [RS_SIZE-1:0] w_wake1;
    logic [RS_SIZE-1:0] w_wake2;
    logic [31:0]        w_wval1  [RS_SIZE];
    logic [31:0]        w_wval2  [RS_SIZE];
    logic [32:0]        w_snoop_i;
    logic [32:0]        w_snoop_j;
    logic               w_dis_o1;
    logic               w_dis_o2;
    logic [31:0]        w_dis_v1;
    logic [31:0]        w_dis_v2;

    // Tag match against both broadcast buses; returns {hit, value}.
    // ALU wins if both match, although unique ROB tags make that impossible.
    function automatic logic [32:0] snoop(
        input logic [TAG_W-1:0] tag,
        input logic             aluOk,
        input logic [TAG_W-1:0] aluTag,
        input logic [31:0]      aluVal,
        input logic             lsbOk,
        input logic [TAG_W-1:0] lsbTag,
        input logic [31:0]      lsbVal
    );
        logic [32:0] res;
        res = {1'b0, aluVal};
        if (aluOk && (tag == aluTag)) begin
            res = {1'b1, aluVal};
        end else if (lsbOk && (tag == lsbTag)) begin
            res = {1'b1, lsbVal};
        end
        return res;
    endfunction

    // Free-slot count and lowest-index free entry. Uses the current busy
    // vector, so an entry being issued this cycle is still counted as taken.
    always_comb begin
        w_free_cnt    = '0;
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_cnt    = w_free_cnt + CNT_W'(1);
                w_alloc_found = 1'b1;
                w_alloc_idx   = IDX_W'(i);
            end
        end
    end

    // Two free slots are kept in reserve to absorb the fetch latency.
    assign bus.rs_full = (w_free_cnt < CNT_W'(2));

    // Lowest-index entry whose operands are both ready. Works on registered
    // state only, so a wakeup or dispatch becomes selectable one cycle later.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (r_busy[i] && r_o1[i] && r_o2[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // Per-entry wakeup decisions for operands still waiting on a tag.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            logic [32:0] s1;
            logic [32:0] s2;
            s1 = snoop(r_q1[i], bus.is_ok, bus.rob_id_from_alu, bus.val_from_alu,
                       bus.lsb_ok, bus.rob_id_from_lsb, bus.val_from_lsb);
            s2 = snoop(r_q2[i], bus.is_ok, bus.rob_id_from_alu, bus.val_from_alu,
                       bus.lsb_ok, bus.rob_id_from_lsb, bus.val_from_lsb);
            w_wake1[i] = r_busy[i] && !r_o1[i] && s1[32];
            w_wake2[i] = r_busy[i] && !r_o2[i] && s2[32];
            w_wval1[i] = s1[31:0];
            w_wval2[i] = s2[31:0];
        end
    end

    // Dispatch capture: an operand whose producer broadcasts in the same
    // cycle is stored as already ready, otherwise it would miss the result.
    always_comb begin
        w_snoop_i = snoop(bus.Qi, bus.is_ok, bus.rob_id_from_alu, bus.val_from_alu,
                          bus.lsb_ok, bus.rob_id_from_lsb, bus.val_from_lsb);
        w_snoop_j = snoop(bus.Qj, bus.is_ok, bus.rob_id_from_alu, bus.val_from_alu,
                          bus.lsb_ok, bus.rob_id_from_lsb, bus.val_from_lsb);
        w_dis_o1  = bus.Oi | w_snoop_i[32];
        w_dis_o2  = bus.Oj | w_snoop_j[32];
        w_dis_v1  = bus.Vi;
        w_dis_v2  = bus.Vj;
        if (!bus.Oi && w_snoop_i[32]) begin
            w_dis_v1 = w_snoop_i[31:0];
        end
        if (!bus.Oj && w_snoop_j[32]) begin
            w_dis_v2 = w_snoop_j[31:0];
        end
    end

    // Main state update. Flush beats everything but reset; otherwise
    // wakeup, issue and dispatch all apply in the same edge. They never
    // collide: wakeup touches only waiting busy entries, issue only a ready
    // busy entry, and dispatch only a non-busy entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= '0;
            r_o1         <= '0;
            r_o2         <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_opcode[i] <= '0;
                r_v1[i]     <= '0;
                r_v2[i]     <= '0;
                r_q1[i]     <= '0;
                r_q2[i]     <= '0;
                r_imm[i]    <= '0;
                r_pc[i]     <= '0;
                r_rob[i]    <= '0;
            end
            r_alu_en     <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_v1     <= '0;
            r_alu_v2     <= '0;
            r_alu_imm    <= '0;
            r_alu_pc     <= '0;
            r_alu_rob_id <= '0;
        end else if (bus.rdy) begin
            if (bus.is_clear) begin
                r_busy   <= '0;
                r_alu_en <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (w_wake1[i]) begin
                        r_v1[i] <= w_wval1[i];
                        r_o1[i] <= 1'b1;
                    end
                    if (w_wake2[i]) begin
                        r_v2[i] <= w_wval2[i];
                        r_o2[i] <= 1'b1;
                    end
                end

                if (w_sel_found) begin
                    r_busy[w_sel_idx] <= 1'b0;
                    r_alu_en          <= 1'b1;
                    r_alu_opcode      <= r_opcode[w_sel_idx];
                    r_alu_v1          <= r_v1[w_sel_idx];
                    r_alu_v2          <= r_v2[w_sel_idx];
                    r_alu_imm         <= r_imm[w_sel_idx];
                    r_alu_pc          <= r_pc[w_sel_idx];
                    r_alu_rob_id      <= r_rob[w_sel_idx];
                end else begin
                    r_alu_en <= 1'b0;
                end

                if (bus.dispatch_rs_en && w_alloc_found) begin
                    r_busy[w_alloc_idx]   <= 1'b1;
                    r_opcode[w_alloc_idx] <= bus.dis_opcode;
                    r_v1[w_alloc_idx]     <= w_dis_v1;
                    r_v2[w_alloc_idx]     <= w_dis_v2;
                    r_q1[w_alloc_idx]     <= bus.Qi;
                    r_q2[w_alloc_idx]     <= bus.Qj;
                    r_o1[w_alloc_idx]     <= w_dis_o1;
                    r_o2[w_alloc_idx]     <= w_dis_o2;
                    r_imm[w_alloc_idx]    <= bus.imm_from_dpc;
                    r_pc[w_alloc_idx]     <= bus.once_pc_from_dpc;
                    r_rob[w_alloc_idx]    <= bus.dis_rob_id;
                end
            end
        end
    end

    assign bus.alu_en     = r_alu_en;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_v1     = r_alu_v1;
    assign bus.alu_v2     = r_alu_v2;
    assign bus.alu_imm    = r_alu_imm;
    assign bus.alu_pc     = r_alu_pc;
    assign bus.alu_rob_id = r_alu_rob_id;

endmodule

// File: tb/tb_reservation_station.sv
// ----------------------------------------------------------------------------
// tb_reservation_station
//
// Purpose: directed scoreboard bench for reservation_station. The stimulus
// process pushes every expected ALU issue into a queue; an independent
// monitor pops and compares whenever the DUT issues.
// ----------------------------------------------------------------------------
module tb_reservation_station;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reservation_station_if bus ();

    reservation_station #(
        .RS_SIZE (8),
        .IDX_W   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  rob;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
    } issue_t;

    issue_t expQ[$];
    int     nCmp  = 0;
    int     nFail = 0;
    bit     monOn = 1'b0;
    logic   edgeRdy = 1'b0;

    // Compare one value and report a failure line when it differs.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_rs_en = 1'b0;
        bus.is_clear       = 1'b0;
        bus.is_ok          = 1'b0;
        bus.lsb_ok         = 1'b0;
    endtask

    // imm and pc are derived from the ROB tag so each issue is distinguishable.
    function automatic logic [31:0] immOf(input logic [3:0] rob);
        return {24'h0, rob, 4'h0};
    endfunction

    function automatic logic [31:0] pcOf(input logic [3:0] rob);
        return 32'h1000 + {26'h0, rob, 2'b00};
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic [3:0] rob,
                                 input logic oi, input logic [3:0] qi, input logic [31:0] vi,
                                 input logic oj, input logic [3:0] qj, input logic [31:0] vj);
        bus.dispatch_rs_en   = 1'b1;
        bus.dis_opcode       = op;
        bus.dis_rob_id       = rob;
        bus.Oi               = oi;
        bus.Qi               = qi;
        bus.Vi               = vi;
        bus.Oj               = oj;
        bus.Qj               = qj;
        bus.Vj               = vj;
        bus.imm_from_dpc     = immOf(rob);
        bus.once_pc_from_dpc = pcOf(rob);
    endtask

    task automatic pushExp(input logic [5:0] op, input logic [3:0] rob,
                           input logic [31:0] v1, input logic [31:0] v2);
        issue_t e;
        e.op  = op;
        e.rob = rob;
        e.v1  = v1;
        e.v2  = v2;
        e.imm = immOf(rob);
        e.pc  = pcOf(rob);
        expQ.push_back(e);
    endtask

    task automatic aluBroadcast(input logic [3:0] tag, input logic [31:0] val);
        bus.is_ok           = 1'b1;
        bus.rob_id_from_alu = tag;
        bus.val_from_alu    = val;
    endtask

    task automatic lsbBroadcast(input logic [3:0] tag, input logic [31:0] val);
        bus.lsb_ok          = 1'b1;
        bus.rob_id_from_lsb = tag;
        bus.val_from_lsb    = val;
    endtask

    // Remember whether the last edge was enabled, so held outputs during
    // rdy=0 are not mistaken for new issues.
    always @(posedge clk) edgeRdy = bus.rdy;

    // Monitor: every new issue must match the oldest expected entry.
    always @(negedge clk) begin
        if (monOn && edgeRdy && !rst && bus.alu_en === 1'b1) begin
            if (expQ.size() == 0) begin
                nCmp++;
                nFail++;
                $display("[TB] FAIL unexpectedIssue: got rob %0d, expected no issue at %0t",
                         bus.alu_rob_id, $time);
            end else begin
                issue_t e;
                e = expQ.pop_front();
                checkOutput("issueRob", {28'h0, bus.alu_rob_id}, {28'h0, e.rob});
                checkOutput("issueOp",  {26'h0, bus.alu_opcode}, {26'h0, e.op});
                checkOutput("issueV1",  bus.alu_v1,  e.v1);
                checkOutput("issueV2",  bus.alu_v2,  e.v2);
                checkOutput("issueImm", bus.alu_imm, e.imm);
                checkOutput("issuePc",  bus.alu_pc,  e.pc);
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        bus.rdy             = 1'b1;
        idle();
        bus.dis_opcode      = '0;
        bus.dis_rob_id      = '0;
        bus.Vi              = '0;
        bus.Vj              = '0;
        bus.Qi              = '0;
        bus.Qj              = '0;
        bus.Oi              = 1'b0;
        bus.Oj              = 1'b0;
        bus.imm_from_dpc    = '0;
        bus.once_pc_from_dpc = '0;
        bus.val_from_alu    = '0;
        bus.rob_id_from_alu = '0;
        bus.val_from_lsb    = '0;
        bus.rob_id_from_lsb = '0;
        #12 rst = 1'b0;

        // Reset state
        checkOutput("rstAluEn",  {31'h0, bus.alu_en}, 32'h0);
        checkOutput("rstRsFull", {31'h0, bus.rs_full}, 32'h0);
        checkOutput("rstAluV1",  bus.alu_v1, 32'h0);
        checkOutput("rstAluRob", {28'h0, bus.alu_rob_id}, 32'h0);
        checkOutput("rstAluOp",  {26'h0, bus.alu_opcode}, 32'h0);
        monOn = 1'b1;
        step();

        // Both operands ready at dispatch: issue one edge later
        applyStimulus(6'h01, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        pushExp(6'h01, 4'd3, 32'd5, 32'd7);
        step();
        idle();
        checkOutput("t1EnAfterDispatch", {31'h0, bus.alu_en}, 32'h0);
        step();
        checkOutput("t1EnIssue", {31'h0, bus.alu_en}, 32'h1);
        checkOutput("t1V1", bus.alu_v1, 32'd5);
        checkOutput("t1V2", bus.alu_v2, 32'd7);
        checkOutput("t1Rob", {28'h0, bus.alu_rob_id}, 32'd3);
        step();
        checkOutput("t1EnDrop", {31'h0, bus.alu_en}, 32'h0);

        // Wait on tag 2, unrelated broadcast first, then the ALU wakes it
        applyStimulus(6'h02, 4'd4, 1'b0, 4'd2, 32'h0, 1'b1, 4'd0, 32'd1);
        pushExp(6'h02, 4'd4, 32'hDEAD, 32'd1);
        step();
        idle();
        aluBroadcast(4'd3, 32'hBAD);
        checkOutput("t2Wait0", {31'h0, bus.alu_en}, 32'h0);
        step();
        idle();
        checkOutput("t2Wait1", {31'h0, bus.alu_en}, 32'h0);
        step();
        checkOutput("t2Wait2", {31'h0, bus.alu_en}, 32'h0);
        aluBroadcast(4'd2, 32'hDEAD);
        step();
        idle();
        checkOutput("t2WakeEdge", {31'h0, bus.alu_en}, 32'h0);
        step();
        checkOutput("t2EnIssue", {31'h0, bus.alu_en}, 32'h1);
        checkOutput("t2V1", bus.alu_v1, 32'hDEAD);
        step();

        // Dispatch on tag 0 while the LSB broadcasts tag 0
        applyStimulus(6'h03, 4'd5, 1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 32'd3);
        lsbBroadcast(4'd0, 32'd9);
        pushExp(6'h03, 4'd5, 32'd9, 32'd3);
        step();
        idle();
        checkOutput("t3EnAfterDispatch", {31'h0, bus.alu_en}, 32'h0);
        step();
        checkOutput("t3EnIssue", {31'h0, bus.alu_en}, 32'h1);
        checkOutput("t3V1", bus.alu_v1, 32'd9);
        step();

        // Fill seven waiting entries: entry k waits on tag 8+k
        for (int k = 0; k < 7; k++) begin
            applyStimulus(6'h04, 4'(k), 1'b0, 4'(8 + k), 32'h0, 1'b1, 4'd0, 32'(k));
            step();
            if (k == 5) checkOutput("t4FullAfter6", {31'h0, bus.rs_full}, 32'h0);
            if (k == 6) checkOutput("t4FullAfter7", {31'h0, bus.rs_full}, 32'h1);
        end
        idle();
        checkOutput("t4NoneReady", {31'h0, bus.alu_en}, 32'h0);
        aluBroadcast(4'd8, 32'h100);
        pushExp(6'h04, 4'd0, 32'h100, 32'd0);
        step();
        idle();
        checkOutput("t4FullAtWake", {31'h0, bus.rs_full}, 32'h1);
        step();
        checkOutput("t4EnIssue0", {31'h0, bus.alu_en}, 32'h1);
        checkOutput("t4Rob0", {28'h0, bus.alu_rob_id}, 32'd0);
        checkOutput("t4FullAfterIssue", {31'h0, bus.rs_full}, 32'h0);

        // Entries 2 and 5 wake together; lower index goes first
        aluBroadcast(4'd10, 32'h222);
        lsbBroadcast(4'd13, 32'h555);
        pushExp(6'h04, 4'd2, 32'h222, 32'd2);
        pushExp(6'h04, 4'd5, 32'h555, 32'd5);
        step();
        idle();
        checkOutput("t4EnAtWake2", {31'h0, bus.alu_en}, 32'h0);
        step();
        checkOutput("t4RobFirst", {28'h0, bus.alu_rob_id}, 32'd2);
        step();
        checkOutput("t4EnSecond", {31'h0, bus.alu_en}, 32'h1);
        checkOutput("t4RobSecond", {28'h0, bus.alu_rob_id}, 32'd5);
        step();
        checkOutput("t4EnDrop", {31'h0, bus.alu_en}, 32'h0);

        // Four entries wait (tags 9,11,12,14); flush with dispatch + match
        bus.is_clear = 1'b1;
        applyStimulus(6'h05, 4'd9, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h22);
        aluBroadcast(4'd9, 32'h999);
        step();
        idle();
        checkOutput("t5EnAfterClear", {31'h0, bus.alu_en}, 32'h0);
        checkOutput("t5FullAfterClear", {31'h0, bus.rs_full}, 32'h0);
        aluBroadcast(4'd11, 32'h1111);
        lsbBroadcast(4'd12, 32'h1212);
        step();
        idle();
        step();
        checkOutput("t5NoIssue0", {31'h0, bus.alu_en}, 32'h0);
        step();
        checkOutput("t5NoIssue1", {31'h0, bus.alu_en}, 32'h0);
        // Six new waiting entries only fit if all eight slots were freed
        for (int k = 0; k < 6; k++) begin
            applyStimulus(6'h06, 4'(k), 1'b0, 4'd15, 32'h0, 1'b0, 4'd15, 32'h0);
            step();
        end
        idle();
        checkOutput("t5FullAfterRefill", {31'h0, bus.rs_full}, 32'h0);
        bus.is_clear = 1'b1;
        step();
        idle();

        // Asynchronous reset while an issue is on the ALU port
        applyStimulus(6'h06, 4'd7, 1'b1, 4'd0, 32'h77, 1'b1, 4'd0, 32'h88);
        pushExp(6'h06, 4'd7, 32'h77, 32'h88);
        step();
        idle();
        step();
        checkOutput("t6EnBeforeRst", {31'h0, bus.alu_en}, 32'h1);
        #6 rst = 1'b1;
        #1;
        checkOutput("t6RstEn",  {31'h0, bus.alu_en}, 32'h0);
        checkOutput("t6RstV1",  bus.alu_v1, 32'h0);
        checkOutput("t6RstV2",  bus.alu_v2, 32'h0);
        checkOutput("t6RstRob", {28'h0, bus.alu_rob_id}, 32'h0);
        checkOutput("t6RstOp",  {26'h0, bus.alu_opcode}, 32'h0);
        checkOutput("t6RstImm", bus.alu_imm, 32'h0);
        checkOutput("t6RstPc",  bus.alu_pc, 32'h0);
        checkOutput("t6RstFull", {31'h0, bus.rs_full}, 32'h0);
        #1 rst = 1'b0;
        step();
        checkOutput("t6EnAfterRst", {31'h0, bus.alu_en}, 32'h0);

        // rdy low for three edges: ready entry waits, dispatch is lost
        applyStimulus(6'h07, 4'd8, 1'b1, 4'd0, 32'hA1, 1'b1, 4'd0, 32'hA2);
        pushExp(6'h07, 4'd8, 32'hA1, 32'hA2);
        step();
        bus.rdy = 1'b0;
        applyStimulus(6'h07, 4'd9, 1'b1, 4'd0, 32'hB1, 1'b1, 4'd0, 32'hB2);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("t7HoldNoIssue", {31'h0, bus.alu_en}, 32'h0);
        end
        idle();
        bus.rdy = 1'b1;
        step();
        checkOutput("t7EnAfterRdy", {31'h0, bus.alu_en}, 32'h1);
        checkOutput("t7Rob", {28'h0, bus.alu_rob_id}, 32'd8);
        bus.rdy = 1'b0;
        step();
        checkOutput("t7HoldEn", {31'h0, bus.alu_en}, 32'h1);
        checkOutput("t7HoldRob", {28'h0, bus.alu_rob_id}, 32'd8);
        bus.rdy = 1'b1;
        step();
        checkOutput("t7EnDrop", {31'h0, bus.alu_en}, 32'h0);
        step();
        checkOutput("t7NoLostDispatch", {31'h0, bus.alu_en}, 32'h0);
        step();

        checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
